// File: rtl/tia_collision_pkg.sv
// tia_collision_pkg
// Shared definitions for the collision block: object bit positions within
// the obj vector, latch index for each of the 15 object pairs, read
// register addresses, and helpers that map a latch index to its two objects.
// No ports.
package tia_collision_pkg;

  localparam int NUM_OBJ = 6;

  typedef logic [NUM_OBJ-1:0] obj_vec_t;

  // Object bit positions in obj: {pf,bl,m1,m0,p1,p0}
  localparam int OBJ_P0 = 0;
  localparam int OBJ_P1 = 1;
  localparam int OBJ_M0 = 2;
  localparam int OBJ_M1 = 3;
  localparam int OBJ_BL = 4;
  localparam int OBJ_PF = 5;

  // Latch index per object pair
  localparam int CX_P0_P1 = 0;
  localparam int CX_P0_M0 = 1;
  localparam int CX_P0_M1 = 2;
  localparam int CX_P0_BL = 3;
  localparam int CX_P0_PF = 4;
  localparam int CX_P1_M0 = 5;
  localparam int CX_P1_M1 = 6;
  localparam int CX_P1_BL = 7;
  localparam int CX_P1_PF = 8;
  localparam int CX_M0_M1 = 9;
  localparam int CX_M0_BL = 10;
  localparam int CX_M0_PF = 11;
  localparam int CX_M1_BL = 12;
  localparam int CX_M1_PF = 13;
  localparam int CX_BL_PF = 14;

  // Read register addresses
  localparam logic [3:0] CXM0P  = 4'h0;
  localparam logic [3:0] CXM1P  = 4'h1;
  localparam logic [3:0] CXP0FB = 4'h2;
  localparam logic [3:0] CXP1FB = 4'h3;
  localparam logic [3:0] CXM0FB = 4'h4;
  localparam logic [3:0] CXM1FB = 4'h5;
  localparam logic [3:0] CXBLPF = 4'h6;
  localparam logic [3:0] CXPPMM = 4'h7;

  // First object of a pair
  function automatic int cx_obj_a(input int idx);
    case (idx)
      CX_P0_P1, CX_P0_M0, CX_P0_M1, CX_P0_BL, CX_P0_PF: return OBJ_P0;
      CX_P1_M0, CX_P1_M1, CX_P1_BL, CX_P1_PF:           return OBJ_P1;
      CX_M0_M1, CX_M0_BL, CX_M0_PF:                     return OBJ_M0;
      CX_M1_BL, CX_M1_PF:                               return OBJ_M1;
      default:                                          return OBJ_BL;
    endcase
  endfunction

  // Second object of a pair
  function automatic int cx_obj_b(input int idx);
    case (idx)
      CX_P0_P1:                               return OBJ_P1;
      CX_P0_M0, CX_P1_M0:                     return OBJ_M0;
      CX_P0_M1, CX_P1_M1, CX_M0_M1:           return OBJ_M1;
      CX_P0_BL, CX_P1_BL, CX_M0_BL, CX_M1_BL: return OBJ_BL;
      default:                                return OBJ_PF;
    endcase
  endfunction

endpackage

// File: rtl/tia_collision_cx_bit.sv
// tia_cx_bit
// One sticky collision latch. Sets when enabled and the pair overlaps,
// stays set until a clear strobe or reset. Clear has priority over set.
// Ports:
//   clk    colour clock
//   r_n    synchronous active-low reset
//   i_set  pair overlap this cycle
//   i_clr  clear strobe
//   i_en   detection enable (low during blanking)
//   o_q    latch state
module tia_cx_bit (
  input  logic clk,
  input  logic r_n,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_en,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!r_n) begin
      r_q <= 1'b0;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else if (i_en && i_set) begin
      r_q <= 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tia_collision.sv
// tia_collision
// Fifteen sticky pairwise collision latches between the six video objects,
// plus the registered CPU read port returning {D7,D6} per register.
// Ports:
//   clk    colour clock
//   r_n    synchronous active-low reset
//   obj    object pixel bits {pf,bl,m1,m0,p1,p0}
//   blank  horizontal/vertical blank, suppresses detection
//   cxclr  clear-all strobe
//   rd     CPU read strobe
//   addr   read address (0x0-0x7 valid, addr[3]=1 reads 00)
//   d      registered read data {D7,D6}
module tia_collision
  import tia_collision_pkg::*;
#(
  parameter int NUM_CX = 15
) (
  input  logic       clk,
  input  logic       r_n,
  input  logic [5:0] obj,
  input  logic       blank,
  input  logic       cxclr,
  input  logic       rd,
  input  logic [3:0] addr,
  output logic [1:0] d
);

  logic [NUM_CX-1:0] w_set;
  logic [NUM_CX-1:0] w_cx;
  logic              w_en;
  logic [1:0]        w_rdata;
  logic [1:0]        r_d;

  assign w_en = ~blank;

  for (genvar g = 0; g < NUM_CX; g++) begin : g_cx
    localparam int A = cx_obj_a(g);
    localparam int B = cx_obj_b(g);

    assign w_set[g] = obj[A] & obj[B];

    tia_cx_bit u_bit (
      .clk   (clk),
      .r_n   (r_n),
      .i_set (w_set[g]),
      .i_clr (cxclr),
      .i_en  (w_en),
      .o_q   (w_cx[g])
    );
  end

  // Read mux works on pre-edge latch state, so a coincident clear or new
  // collision is not reflected in this read.
  always_comb begin
    w_rdata = 2'b00;
    case (addr)
      CXM0P:  w_rdata = {w_cx[CX_P1_M0], w_cx[CX_P0_M0]};
      CXM1P:  w_rdata = {w_cx[CX_P0_M1], w_cx[CX_P1_M1]};
      CXP0FB: w_rdata = {w_cx[CX_P0_PF], w_cx[CX_P0_BL]};
      CXP1FB: w_rdata = {w_cx[CX_P1_PF], w_cx[CX_P1_BL]};
      CXM0FB: w_rdata = {w_cx[CX_M0_PF], w_cx[CX_M0_BL]};
      CXM1FB: w_rdata = {w_cx[CX_M1_PF], w_cx[CX_M1_BL]};
      CXBLPF: w_rdata = {w_cx[CX_BL_PF], 1'b0};
      CXPPMM: w_rdata = {w_cx[CX_P0_P1], w_cx[CX_M0_M1]};
      default: w_rdata = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r_n) begin
      r_d <= 2'b00;
    end else if (rd) begin
      r_d <= w_rdata;
    end
  end

  assign d = r_d;

endmodule
